// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_pkg
// Description : Shared state encoding and sizing helper for the truth-table
//               sweeper and its hold timer.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sweeper_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits needed to count 0..value-1, never less than one so that a
  // single-cycle hold still gets a legal (if constant) counter.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : truth_table_sweeper_pkg
`default_nettype wire

// File: rtl/truth_table_sweeper_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_hold_timer
// Description : Hold-window counter. Counts 0..HOLD_CYCLES-1 while enabled,
//               wraps to zero after the terminal count, and flags the last
//               cycle of each window.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               clr_i   - force the count to zero (has priority over en_i)
//               en_i    - advance the count this cycle
//               tc_o    - count is at HOLD_CYCLES-1 (last cycle of window)
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper_hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  import truth_table_sweeper_pkg::*;

  localparam int             c_TW       = clog2_min1(HOLD_CYCLES);
  localparam logic [c_TW-1:0] c_LAST_CNT = c_TW'(HOLD_CYCLES - 1);

  logic [c_TW-1:0] cnt_q;
  logic [c_TW-1:0] cnt_d;

  assign tc_o = (cnt_q == c_LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Wrap at the terminal count so the next window starts at zero.
      if (tc_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : truth_table_sweeper_hold_timer
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives every input combination of a small combinational block
//               in ascending order, holds each for HOLD_CYCLES cycles, samples
//               the block's output in the last cycle of each window and
//               assembles the resulting truth table.
// Ports       : clk         - clock, rising edge
//               rst_n       - asynchronous active-low reset
//               start       - begin a sweep (honoured only when idle)
//               abort       - stop a sweep in progress, back to idle
//               f_in        - output of the block under test
//               vec         - stimulus to the block under test (MSB = "a")
//               sample_stb  - one-cycle pulse following each capture
//               busy        - sweep in progress
//               done        - one-cycle pulse after a complete sweep
//               truth_table - bit i = f_in captured while vec == i
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec,
  output logic                 sample_stb,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table
);
  import truth_table_sweeper_pkg::*;

  localparam int              c_NUM_VEC  = 2**N_IN;
  localparam logic [N_IN-1:0] c_LAST_IDX = {N_IN{1'b1}};

  state_e                 state_q, state_d;
  logic [N_IN-1:0]        idx_q, idx_d;
  logic [N_IN-1:0]        vec_q, vec_d;
  logic                   stb_q, stb_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [c_NUM_VEC-1:0]   tt_q, tt_d;

  logic                   w_tc;
  logic                   w_capture;

  // The timer is held at zero outside DRIVE, so the first window after a
  // start always begins from a clean count.
  truth_table_sweeper_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != ST_DRIVE),
    .en_i  (state_q == ST_DRIVE),
    .tc_o  (w_tc)
  );

  assign w_capture = (state_q == ST_DRIVE) && w_tc;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tt_d    = tt_q;

    case (state_q)
      ST_IDLE: begin
        // Abort beats a simultaneous start.
        if (start && !abort) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          tt_d    = '0;
        end
      end

      ST_DRIVE: begin
        if (w_capture) begin
          tt_d[idx_q] = f_in;
          if (idx_q == c_LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        // A capture on the same edge as abort is still kept above; only the
        // state transition is overridden.
        if (abort) begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_comb begin
    vec_d  = (state_d == ST_DRIVE) ? idx_d : '0;
    busy_d = (state_d == ST_DRIVE);
    done_d = (state_d == ST_DONE);
    stb_d  = w_capture;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
    end
  end

  assign vec         = vec_q;
  assign sample_stb  = stb_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench. Two sweepers (HOLD_CYCLES 10 and 1) are
//               driven against function tables held in the bench; expected
//               stimulus timing and captured tables come from the sweep
//               rules applied with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st, ab;
  logic        sel;            // 0: DUT with hold 10, 1: DUT with hold 1
  logic [15:0] fn_tab;

  logic        start_a, abort_a, f_a, stb_a, busy_a, done_a;
  logic [3:0]  vec_a;
  logic [15:0] tt_a;
  logic        start_b, abort_b, f_b, stb_b, busy_b, done_b;
  logic [3:0]  vec_b;
  logic [15:0] tt_b;

  logic [3:0]  o_vec;
  logic        o_stb, o_busy, o_done;
  logic [15:0] o_tt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign start_a = st & ~sel;
  assign abort_a = ab & ~sel;
  assign start_b = st & sel;
  assign abort_b = ab & sel;
  assign f_a     = fn_tab[vec_a];
  assign f_b     = fn_tab[vec_b];

  assign o_vec  = sel ? vec_b  : vec_a;
  assign o_stb  = sel ? stb_b  : stb_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_tt   = sel ? tt_b   : tt_a;

  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(10)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .abort       (abort_a),
    .f_in        (f_a),
    .vec         (vec_a),
    .sample_stb  (stb_a),
    .busy        (busy_a),
    .done        (done_a),
    .truth_table (tt_a)
  );

  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(1)) u_dut_h1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .abort       (abort_b),
    .f_in        (f_b),
    .vec         (vec_b),
    .sample_stb  (stb_b),
    .busy        (busy_b),
    .done        (done_b),
    .truth_table (tt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One sweep: start pulse, optional abort at sample m == abort_at (abort is
  // seen by the DUT on the following edge), optional start re-pulses mid
  // sweep and in the done cycle. m counts edges since the start edge.
  task automatic sweep(input string name, input logic [15:0] tab, input int hold,
                       input int abort_at, input bit repulse);
    bit          expect_done;
    int          end_m, ncap;
    int          vec_bad, busy_bad, stb_bad, done_bad, nstb, ndone;
    logic [15:0] exp_tt;
    logic [3:0]  exp_vec;
    bit          exp_busy, exp_stb, exp_done;

    fn_tab      = tab;
    expect_done = (abort_at < 0);
    end_m       = expect_done ? 16 * hold : abort_at + 1;
    ncap        = expect_done ? 16 : (abort_at + 1) / hold;
    exp_tt      = '0;
    for (int i = 0; i < ncap; i++) exp_tt[i] = tab[i];
    vec_bad = 0; busy_bad = 0; stb_bad = 0; done_bad = 0; nstb = 0; ndone = 0;

    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    for (int m = 0; m <= end_m + 2; m++) begin
      exp_vec  = (m < end_m) ? 4'(m / hold) : 4'd0;
      exp_busy = (m < end_m);
      exp_stb  = (m >= hold) && (m % hold == 0) && (m / hold <= ncap);
      exp_done = expect_done && (m == end_m);
      if (o_vec  !== exp_vec)  vec_bad++;
      if (o_busy !== exp_busy) busy_bad++;
      if (o_stb  !== exp_stb)  stb_bad++;
      if (o_done !== exp_done) done_bad++;
      if (o_stb)  nstb++;
      if (o_done) ndone++;
      ab = (m == abort_at);
      st = repulse && ((m == 7 * hold + 3) || (m == end_m));
      @(negedge clk);
    end
    st = 1'b0;
    ab = 1'b0;
    check_eq({name, " vec timing errs"},  vec_bad,  0);
    check_eq({name, " busy timing errs"}, busy_bad, 0);
    check_eq({name, " stb timing errs"},  stb_bad,  0);
    check_eq({name, " done timing errs"}, done_bad, 0);
    check_eq({name, " stb count"},        nstb,     ncap);
    check_eq({name, " done count"},       ndone,    expect_done ? 1 : 0);
    check_eq({name, " truth_table"},      o_tt,     exp_tt);
  endtask

  initial begin
    logic [15:0] par_tab, and_tab, rnd_tab;
    int          a;

    st = 1'b0; ab = 1'b0; sel = 1'b0; fn_tab = '0;
    for (int i = 0; i < 16; i++) begin
      par_tab[i] = ($countones(i) % 2) == 1;
      and_tab[i] = (i == 15);
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset vec",  o_vec,  0);
    check_eq("reset busy", o_busy, 0);
    check_eq("reset done", o_done, 0);
    check_eq("reset stb",  o_stb,  0);
    check_eq("reset tt",   o_tt,   0);
    rst_n = 1'b1;
    @(negedge clk);

    // Parity sweep, hold 10
    sweep("parity", par_tab, 10, -1, 1'b0);

    // Re-pulsed start mid sweep and in the done cycle
    sweep("repulse", par_tab, 10, -1, 1'b1);

    // Abort while vec == 6 with f_in constant 1
    a = 60 + int'($urandom_range(0, 9));
    sweep("abort_v6", 16'hFFFF, 10, a, 1'b0);

    // Random tables with random aborts
    for (int r = 0; r < 3; r++) begin
      rnd_tab = 16'($urandom);
      a = int'($urandom_range(0, 158));
      sweep("rand_abort", rnd_tab, 10, a, 1'b0);
      sweep("rand_full", rnd_tab, 10, -1, 1'b0);
    end

    // start with abort in IDLE
    @(negedge clk); st = 1'b1; ab = 1'b1;
    @(negedge clk); st = 1'b0; ab = 1'b0;
    check_eq("start+abort busy", o_busy, 0);
    check_eq("start+abort vec",  o_vec,  0);
    @(negedge clk);
    check_eq("start+abort busy2", o_busy, 0);

    // Asynchronous reset while vec == 5
    fn_tab = par_tab;
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
    repeat (55) @(negedge clk);
    check_eq("pre-reset vec", o_vec, 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst vec",  o_vec,  0);
    check_eq("async rst busy", o_busy, 0);
    check_eq("async rst stb",  o_stb,  0);
    check_eq("async rst done", o_done, 0);
    check_eq("async rst tt",   o_tt,   0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sweep("post-reset", par_tab, 10, -1, 1'b0);

    // Hold of one cycle
    sel = 1'b1;
    @(negedge clk);
    sweep("and_h1", and_tab, 1, -1, 1'b0);
    rnd_tab = 16'($urandom);
    sweep("rand_h1", rnd_tab, 1, -1, 1'b1);
    sweep("abort_h1", rnd_tab, 1, int'($urandom_range(0, 14)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_truth_table_sweeper
`default_nettype wire
